// File: rtl/ahci_fis_pkg.sv
// Shared AHCI receive-FIS definitions: word layout, FIS type codes and the
// word-index helper used by the field capture logic.
package ahci_fis_pkg;

  localparam int unsigned FIS_WORD_W = 36;
  localparam int unsigned SOF_BIT    = 35;
  localparam int unsigned EOF_BIT    = 34;
  localparam int unsigned WIDX_W     = 3;

  localparam logic [7:0] FIS_REG_D2H   = 8'h34;
  localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;
  localparam logic [7:0] FIS_DMA_SETUP = 8'h41;
  localparam logic [7:0] FIS_SDB       = 8'hA1;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [1:0]  spare;
    logic [31:0] data;
  } fis_word_t;

  // Word index counts up per pop and sticks at its maximum on long frames.
  function automatic logic [WIDX_W-1:0] widx_inc(input logic [WIDX_W-1:0] w);
    return (w == WIDX_W'(7)) ? w : w + WIDX_W'(1);
  endfunction

endpackage

// File: rtl/rx_fis_fifo_if.sv
// Write/read handshake and captured FIS field bundle of rx_fis_fifo.
interface rx_fis_fifo_if
  import ahci_fis_pkg::*;
#(
  parameter int unsigned C_DEPTH = 512
);
  localparam int unsigned C_FCNT_W = $clog2(C_DEPTH) + 1;

  logic [FIS_WORD_W-1:0] wr_di;
  logic                  wr_en;
  logic                  wr_full;
  logic                  wr_err;
  logic [FIS_WORD_W-1:0] rd_do;
  logic                  rd_en;
  logic                  rd_empty;
  logic                  rd_err;
  logic                  frame_rdy;
  logic [C_FCNT_W-1:0]   frame_cnt;
  logic [31:0]           fis_hdr;
  logic [31:0]           PxSIG;
  logic [7:0]            Estatus;
  logic [15:0]           Transfer_Count;
  logic [5:0]            DS_TAG;
  logic [31:0]           DS_offset;
  logic [31:0]           DS_Count;
  logic [31:0]           SDB_SActive;

  modport master (
    output wr_di, wr_en, rd_en,
    input  wr_full, wr_err, rd_do, rd_empty, rd_err, frame_rdy, frame_cnt,
           fis_hdr, PxSIG, Estatus, Transfer_Count, DS_TAG, DS_offset,
           DS_Count, SDB_SActive
  );

  modport slave (
    input  wr_di, wr_en, rd_en,
    output wr_full, wr_err, rd_do, rd_empty, rd_err, frame_rdy, frame_cnt,
           fis_hdr, PxSIG, Estatus, Transfer_Count, DS_TAG, DS_offset,
           DS_Count, SDB_SActive
  );

endinterface

// File: rtl/rx_fis_ram.sv
// Single-clock FIFO storage: one synchronous write port, asynchronous read.
module rx_fis_ram
  import ahci_fis_pkg::*;
#(
  parameter int unsigned C_DEPTH = 512,
  localparam int unsigned C_AW   = $clog2(C_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [C_AW-1:0]       waddr,
  input  logic [FIS_WORD_W-1:0] wdata,
  input  logic [C_AW-1:0]       raddr,
  output logic [FIS_WORD_W-1:0] rdata
);

  logic [FIS_WORD_W-1:0] mem [C_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fis_fifo.sv
// Receive FIS FIFO: first-word-fall-through word store with frame counting
// and capture of selected FIS fields as words are popped.
module rx_fis_fifo
  import ahci_fis_pkg::*;
#(
  parameter int unsigned C_DEPTH = 512
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  rx_fis_fifo_if.slave bus
);

  localparam int unsigned C_AW     = $clog2(C_DEPTH);
  localparam int unsigned C_FCNT_W = C_AW + 1;

  logic [C_AW-1:0]     wr_ptr;
  logic [C_AW-1:0]     rd_ptr;
  logic [C_FCNT_W-1:0] occ;
  logic [C_FCNT_W-1:0] frame_cnt_q;
  logic [WIDX_W-1:0]   widx;
  logic                wr_err_q;
  logic                rd_err_q;
  logic [31:0]         fis_hdr_q;
  logic [31:0]         pxsig_q;
  logic [7:0]          estatus_q;
  logic [15:0]         xfer_cnt_q;
  logic [5:0]          ds_tag_q;
  logic [31:0]         ds_offset_q;
  logic [31:0]         ds_count_q;
  logic [31:0]         sdb_sactive_q;

  logic [FIS_WORD_W-1:0] ram_rdata;
  fis_word_t             head;
  fis_word_t             wr_word;
  logic                  full_c;
  logic                  empty_c;
  logic                  push_c;
  logic                  pop_c;
  logic [7:0]            ftype_c;

  assign head    = fis_word_t'(ram_rdata);
  assign wr_word = fis_word_t'(bus.wr_di);
  assign full_c  = (occ == C_FCNT_W'(C_DEPTH));
  assign empty_c = (occ == '0);
  assign pop_c   = bus.rd_en && !empty_c;
  // A write while full is still taken when the head leaves in the same cycle.
  assign push_c  = bus.wr_en && (!full_c || bus.rd_en);
  assign ftype_c = fis_hdr_q[7:0];

  rx_fis_ram #(.C_DEPTH(C_DEPTH)) u_ram (
    .clk   (sys_clk),
    .we    (push_c),
    .waddr (wr_ptr),
    .wdata (bus.wr_di),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Pointers, occupancy, frame count and error pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      frame_cnt_q <= '0;
      wr_err_q    <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && full_c && !bus.rd_en;
      rd_err_q <= bus.rd_en && empty_c;
      if (push_c) wr_ptr <= wr_ptr + C_AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + C_AW'(1);
      case ({push_c, pop_c})
        2'b10:   occ <= occ + C_FCNT_W'(1);
        2'b01:   occ <= occ - C_FCNT_W'(1);
        default: occ <= occ;
      endcase
      case ({push_c && wr_word.eof, pop_c && head.eof})
        2'b10:   frame_cnt_q <= frame_cnt_q + C_FCNT_W'(1);
        2'b01:   frame_cnt_q <= frame_cnt_q - C_FCNT_W'(1);
        default: frame_cnt_q <= frame_cnt_q;
      endcase
    end
  end

  // Word index tracking and field capture on popped words.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      widx          <= '0;
      fis_hdr_q     <= '0;
      pxsig_q       <= '0;
      estatus_q     <= '0;
      xfer_cnt_q    <= '0;
      ds_tag_q      <= '0;
      ds_offset_q   <= '0;
      ds_count_q    <= '0;
      sdb_sactive_q <= '0;
    end else if (pop_c) begin
      if (head.sof) begin
        fis_hdr_q <= head.data;
        widx      <= head.eof ? WIDX_W'(0) : WIDX_W'(1);
      end else begin
        widx <= head.eof ? WIDX_W'(0) : widx_inc(widx);
        case (ftype_c)
          FIS_REG_D2H: begin
            if (widx == WIDX_W'(1)) pxsig_q[31:8] <= head.data[23:0];
            if (widx == WIDX_W'(3)) pxsig_q[7:0]  <= head.data[7:0];
          end
          FIS_PIO_SETUP: begin
            if (widx == WIDX_W'(3)) estatus_q  <= head.data[31:24];
            if (widx == WIDX_W'(4)) xfer_cnt_q <= head.data[15:0];
          end
          FIS_DMA_SETUP: begin
            if (widx == WIDX_W'(1)) ds_tag_q    <= head.data[5:0];
            if (widx == WIDX_W'(4)) ds_offset_q <= head.data;
            if (widx == WIDX_W'(5)) ds_count_q  <= head.data;
          end
          FIS_SDB: begin
            if (widx == WIDX_W'(1)) sdb_sactive_q <= head.data;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rd_do          = ram_rdata;
  assign bus.wr_full        = full_c;
  assign bus.rd_empty       = empty_c;
  assign bus.wr_err         = wr_err_q;
  assign bus.rd_err         = rd_err_q;
  assign bus.frame_cnt      = frame_cnt_q;
  assign bus.frame_rdy      = (frame_cnt_q != '0);
  assign bus.fis_hdr        = fis_hdr_q;
  assign bus.PxSIG          = pxsig_q;
  assign bus.Estatus        = estatus_q;
  assign bus.Transfer_Count = xfer_cnt_q;
  assign bus.DS_TAG         = ds_tag_q;
  assign bus.DS_offset      = ds_offset_q;
  assign bus.DS_Count       = ds_count_q;
  assign bus.SDB_SActive    = sdb_sactive_q;

endmodule

// File: tb/tb_rx_fis_fifo.sv
// Self-checking bench for rx_fis_fifo: scoreboarded data path, per-cycle flag
// model, a frame table for field capture and hand-written corner sequences.
module tb_rx_fis_fifo;
  import ahci_fis_pkg::*;

  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [31:0] hdr;
    logic [31:0] px;
    logic [7:0]  es;
    logic [15:0] tc;
    logic [5:0]  tag;
    logic [31:0] off;
    logic [31:0] cnt;
    logic [31:0] sact;
  } fields_t;

  typedef struct {
    int                 len;
    logic [11:0][35:0]  w;
    fields_t            exp;
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  rx_fis_fifo_if #(.C_DEPTH(DEPTH)) bus ();

  rx_fis_fifo #(.C_DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks;
  int          failures;
  logic [35:0] sb [$];
  int          m_occ;
  int          m_fcnt;
  vec_t        vecs [7];

  function automatic logic [35:0] fw(input logic sof, input logic eof, input logic [31:0] d);
    return {sof, eof, 2'b00, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_fields(input fields_t e);
    chk("fis_hdr",        64'(bus.fis_hdr),        64'(e.hdr));
    chk("PxSIG",          64'(bus.PxSIG),          64'(e.px));
    chk("Estatus",        64'(bus.Estatus),        64'(e.es));
    chk("Transfer_Count", 64'(bus.Transfer_Count), 64'(e.tc));
    chk("DS_TAG",         64'(bus.DS_TAG),         64'(e.tag));
    chk("DS_offset",      64'(bus.DS_offset),      64'(e.off));
    chk("DS_Count",       64'(bus.DS_Count),       64'(e.cnt));
    chk("SDB_SActive",    64'(bus.SDB_SActive),    64'(e.sact));
  endtask

  // One clock with the given strobes; model decides acceptance and errors.
  task automatic do_cycle(input logic we, input logic [35:0] di, input logic re);
    logic        exp_werr;
    logic        exp_rerr;
    logic        wacc;
    logic        racc;
    logic [35:0] head;
    exp_werr = we && (m_occ == int'(DEPTH)) && !re;
    exp_rerr = re && (m_occ == 0);
    racc     = re && (m_occ != 0);
    wacc     = we && ((m_occ != int'(DEPTH)) || re);
    bus.wr_en = we;
    bus.wr_di = di;
    bus.rd_en = re;
    if (racc) begin
      head = sb.pop_front();
      chk("rd_do", 64'(bus.rd_do), 64'(head));
      if (head[EOF_BIT]) m_fcnt--;
      m_occ--;
    end
    if (wacc) begin
      sb.push_back(di);
      if (di[EOF_BIT]) m_fcnt++;
      m_occ++;
    end
    @(posedge sys_clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("wr_err",    64'(bus.wr_err),    64'(exp_werr));
    chk("rd_err",    64'(bus.rd_err),    64'(exp_rerr));
    chk("rd_empty",  64'(bus.rd_empty),  64'(m_occ == 0));
    chk("wr_full",   64'(bus.wr_full),   64'(m_occ == int'(DEPTH)));
    chk("frame_cnt", 64'(bus.frame_cnt), 64'(m_fcnt));
    chk("frame_rdy", 64'(bus.frame_rdy), 64'(m_fcnt != 0));
  endtask

  task automatic fill_table();
    fields_t f;
    f = '0;
    // Reg D2H
    vecs[0].len = 5;
    vecs[0].w = '0;
    vecs[0].w[0] = fw(1, 0, 32'h0000_0034);
    vecs[0].w[1] = fw(0, 0, 32'h00AA_BBCC);
    vecs[0].w[2] = fw(0, 0, 32'h0);
    vecs[0].w[3] = fw(0, 0, 32'h0000_0011);
    vecs[0].w[4] = fw(0, 1, 32'h0);
    f.hdr = 32'h34; f.px = 32'hAABB_CC11;
    vecs[0].exp = f;
    // PIO Setup
    vecs[1].len = 5;
    vecs[1].w = '0;
    vecs[1].w[0] = fw(1, 0, 32'h0000_005F);
    vecs[1].w[1] = fw(0, 0, 32'hFFFF_FFFF);
    vecs[1].w[2] = fw(0, 0, 32'hFFFF_FFFF);
    vecs[1].w[3] = fw(0, 0, 32'h7F00_0000);
    vecs[1].w[4] = fw(0, 1, 32'h0000_0200);
    f.hdr = 32'h5F; f.es = 8'h7F; f.tc = 16'h0200;
    vecs[1].exp = f;
    // DMA Setup
    vecs[2].len = 6;
    vecs[2].w = '0;
    vecs[2].w[0] = fw(1, 0, 32'h0000_0041);
    vecs[2].w[1] = fw(0, 0, 32'h0000_0005);
    vecs[2].w[2] = fw(0, 0, 32'h0);
    vecs[2].w[3] = fw(0, 0, 32'h0);
    vecs[2].w[4] = fw(0, 0, 32'h0000_0100);
    vecs[2].w[5] = fw(0, 1, 32'h0000_2000);
    f.hdr = 32'h41; f.tag = 6'd5; f.off = 32'h100; f.cnt = 32'h2000;
    vecs[2].exp = f;
    // Set Device Bits
    vecs[3].len = 2;
    vecs[3].w = '0;
    vecs[3].w[0] = fw(1, 0, 32'h0000_00A1);
    vecs[3].w[1] = fw(0, 1, 32'h1234_5678);
    f.hdr = 32'hA1; f.sact = 32'h1234_5678;
    vecs[3].exp = f;
    // Single SOF+EOF word: header only
    vecs[4].len = 1;
    vecs[4].w = '0;
    vecs[4].w[0] = fw(1, 1, 32'hFFFF_FF34);
    f.hdr = 32'hFFFF_FF34;
    vecs[4].exp = f;
    // Missing EOF, frame restarted by a new SOF
    vecs[5].len = 4;
    vecs[5].w = '0;
    vecs[5].w[0] = fw(1, 0, 32'h0000_0034);
    vecs[5].w[1] = fw(0, 0, 32'h0011_1111);
    vecs[5].w[2] = fw(1, 0, 32'h0000_00A1);
    vecs[5].w[3] = fw(0, 1, 32'hCAFE_BABE);
    f.hdr = 32'hA1; f.px = 32'h1111_1111; f.sact = 32'hCAFE_BABE;
    vecs[5].exp = f;
    // Long DMA Setup: index must stick at 7, not wrap to 1
    vecs[6].len = 11;
    vecs[6].w = '0;
    vecs[6].w[0]  = fw(1, 0, 32'h0000_0041);
    vecs[6].w[1]  = fw(0, 0, 32'h0000_0007);
    vecs[6].w[4]  = fw(0, 0, 32'h0000_0300);
    vecs[6].w[5]  = fw(0, 0, 32'h0000_0400);
    vecs[6].w[8]  = fw(0, 0, 32'h0000_003F);
    vecs[6].w[9]  = fw(0, 0, 32'h0000_003F);
    vecs[6].w[10] = fw(0, 1, 32'h0000_003F);
    f.hdr = 32'h41; f.tag = 6'd7; f.off = 32'h300; f.cnt = 32'h400;
    vecs[6].exp = f;
  endtask

  initial begin
    fields_t zero_f;
    fields_t sdb_f;
    logic [35:0] d;
    checks    = 0;
    failures  = 0;
    m_occ     = 0;
    m_fcnt    = 0;
    zero_f    = '0;
    sys_rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_di = '0;
    fill_table();

    #1;
    chk("rst_rd_empty",  64'(bus.rd_empty),  64'(1));
    chk("rst_wr_full",   64'(bus.wr_full),   64'(0));
    chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'(0));
    chk("rst_frame_rdy", 64'(bus.frame_rdy), 64'(0));
    chk("rst_wr_err",    64'(bus.wr_err),    64'(0));
    chk("rst_rd_err",    64'(bus.rd_err),    64'(0));
    chk_fields(zero_f);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Pop on empty: error pulse, read pointer must not move
    do_cycle(0, '0, 1);
    do_cycle(1, fw(0, 0, 32'h1357_9BDF), 0);
    do_cycle(0, '0, 1);

    // Field capture table
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].len; k++) do_cycle(1, vecs[v].w[k], 0);
      for (int k = 0; k < vecs[v].len; k++) do_cycle(0, '0, 1);
      chk_fields(vecs[v].exp);
    end

    // Fill to full, overflow attempt, write+pop while full, drain across wrap
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = {2'b00, 2'($urandom_range(0, 3)), 32'h0101_0101 * 32'(i + 1)};
      do_cycle(1, d, 0);
    end
    do_cycle(1, fw(0, 0, 32'hDEAD_0017), 0);
    do_cycle(1, fw(0, 0, 32'hBEEF_0018), 1);
    chk("full_after_both", 64'(bus.wr_full), 64'(1));
    for (int i = 0; i < int'(DEPTH); i++) do_cycle(0, '0, 1);
    do_cycle(0, '0, 1);

    // Three 2-word frames, then EOF pop concurrent with EOF write
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, fw(1, 0, 32'h0000_00A1), 0);
      do_cycle(1, fw(0, 1, 32'h0000_1000 + 32'(i)), 0);
    end
    chk("three_frames", 64'(bus.frame_cnt), 64'(3));
    do_cycle(0, '0, 1);
    do_cycle(1, fw(0, 1, 32'h0000_2000), 1);
    chk("eof_pop_push", 64'(bus.frame_cnt), 64'(3));
    while (m_occ != 0) do_cycle(0, '0, 1);

    // Reset mid-frame with two complete frames queued
    do_cycle(1, fw(1, 0, 32'h0000_00A1), 0);
    do_cycle(1, fw(0, 1, 32'h0000_0001), 0);
    do_cycle(1, fw(1, 0, 32'h0000_00A1), 0);
    do_cycle(1, fw(0, 1, 32'h0000_0002), 0);
    do_cycle(1, fw(1, 0, 32'h0000_0034), 0);
    do_cycle(0, '0, 1);
    chk("pre_rst_fcnt", 64'(bus.frame_cnt), 64'(2));
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_empty",  64'(bus.rd_empty),  64'(1));
    chk("mid_rst_frame_cnt", 64'(bus.frame_cnt), 64'(0));
    chk("mid_rst_frame_rdy", 64'(bus.frame_rdy), 64'(0));
    chk_fields(zero_f);
    sb.delete();
    m_occ  = 0;
    m_fcnt = 0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    do_cycle(1, fw(1, 0, 32'h0000_00A1), 0);
    do_cycle(1, fw(0, 1, 32'h0000_00F0), 0);
    do_cycle(0, '0, 1);
    do_cycle(0, '0, 1);
    sdb_f      = '0;
    sdb_f.hdr  = 32'hA1;
    sdb_f.sact = 32'hF0;
    chk_fields(sdb_f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
